// File: rtl/dequantizer_pkg.sv
// Shared constants, state encoding and the dequantisation arithmetic helper.
package dequantizer_pkg;

    localparam int COEF_BIT       = 12;
    localparam int QT_BIT         = 8;
    localparam int Q_BIT          = 32;
    localparam int Q_FRAC_BIT     = 16;
    localparam int BLOCK_BIT      = 3;
    localparam int BLOCK_SIZE     = 8;
    localparam int BLOCK_AREA     = 64;
    localparam int BLOCK_AREA_BIT = 6;
    localparam int RUN_BIT        = 4;

    // Product of a signed coefficient and an unsigned table entry.
    localparam int PROD_BIT  = COEF_BIT + QT_BIT;
    // Integer part of the output fixed-point word.
    localparam int Q_INT_BIT = Q_BIT - Q_FRAC_BIT;

    localparam logic [BLOCK_AREA_BIT-1:0] LAST_K = BLOCK_AREA_BIT'(BLOCK_AREA - 1);

    localparam logic signed [PROD_BIT-1:0] SAT_MAX = PROD_BIT'((2 ** (Q_INT_BIT - 1)) - 1);
    localparam logic signed [PROD_BIT-1:0] SAT_MIN = PROD_BIT'(-(2 ** (Q_INT_BIT - 1)));

    // BOS: between blocks, BLOK: consuming symbols, DOLDUR: zero-filling to k=63.
    typedef enum logic [1:0] {
        ST_BOS    = 2'd0,
        ST_BLOK   = 2'd1,
        ST_DOLDUR = 2'd2
    } dq_state_e;

    // Multiply, saturate to the integer range of the output, then place the
    // integer part above the fractional bits.
    function automatic logic [Q_BIT-1:0] deq_scale(
        input logic signed [COEF_BIT-1:0] v,
        input logic        [QT_BIT-1:0]   q
    );
        logic signed [PROD_BIT-1:0]  p;
        logic signed [Q_INT_BIT-1:0] s;
        p = v * $signed({1'b0, q});
        if (p > SAT_MAX) begin
            s = {1'b0, {(Q_INT_BIT-1){1'b1}}};
        end else if (p < SAT_MIN) begin
            s = {1'b1, {(Q_INT_BIT-1){1'b0}}};
        end else begin
            s = p[Q_INT_BIT-1:0];
        end
        return {s, {Q_FRAC_BIT{1'b0}}};
    endfunction

endpackage

// File: rtl/dequantizer_zigzag_lut.sv
// Zigzag scan position k -> (row, col) inside an 8x8 block, standard JPEG order.
module zigzag_lut
    import dequantizer_pkg::*;
(
    input  logic [BLOCK_AREA_BIT-1:0] k_i,
    output logic [BLOCK_BIT-1:0]      row_o,
    output logic [BLOCK_BIT-1:0]      col_o
);

    // Entries are written as 6'oRC: upper octal digit row, lower digit column.
    logic [2*BLOCK_BIT-1:0] rc;

    // Pure lookup of the zigzag table.
    always_comb begin
        rc = '0;
        case (k_i)
            6'd0:  rc = 6'o00;  6'd1:  rc = 6'o01;  6'd2:  rc = 6'o10;  6'd3:  rc = 6'o20;
            6'd4:  rc = 6'o11;  6'd5:  rc = 6'o02;  6'd6:  rc = 6'o03;  6'd7:  rc = 6'o12;
            6'd8:  rc = 6'o21;  6'd9:  rc = 6'o30;  6'd10: rc = 6'o40;  6'd11: rc = 6'o31;
            6'd12: rc = 6'o22;  6'd13: rc = 6'o13;  6'd14: rc = 6'o04;  6'd15: rc = 6'o05;
            6'd16: rc = 6'o14;  6'd17: rc = 6'o23;  6'd18: rc = 6'o32;  6'd19: rc = 6'o41;
            6'd20: rc = 6'o50;  6'd21: rc = 6'o60;  6'd22: rc = 6'o51;  6'd23: rc = 6'o42;
            6'd24: rc = 6'o33;  6'd25: rc = 6'o24;  6'd26: rc = 6'o15;  6'd27: rc = 6'o06;
            6'd28: rc = 6'o07;  6'd29: rc = 6'o16;  6'd30: rc = 6'o25;  6'd31: rc = 6'o34;
            6'd32: rc = 6'o43;  6'd33: rc = 6'o52;  6'd34: rc = 6'o61;  6'd35: rc = 6'o70;
            6'd36: rc = 6'o71;  6'd37: rc = 6'o62;  6'd38: rc = 6'o53;  6'd39: rc = 6'o44;
            6'd40: rc = 6'o35;  6'd41: rc = 6'o26;  6'd42: rc = 6'o17;  6'd43: rc = 6'o27;
            6'd44: rc = 6'o36;  6'd45: rc = 6'o45;  6'd46: rc = 6'o54;  6'd47: rc = 6'o63;
            6'd48: rc = 6'o72;  6'd49: rc = 6'o73;  6'd50: rc = 6'o64;  6'd51: rc = 6'o55;
            6'd52: rc = 6'o46;  6'd53: rc = 6'o37;  6'd54: rc = 6'o47;  6'd55: rc = 6'o56;
            6'd56: rc = 6'o65;  6'd57: rc = 6'o74;  6'd58: rc = 6'o75;  6'd59: rc = 6'o66;
            6'd60: rc = 6'o57;  6'd61: rc = 6'o67;  6'd62: rc = 6'o76;  6'd63: rc = 6'o77;
            default: rc = '0;
        endcase
    end

    assign row_o = rc[2*BLOCK_BIT-1:BLOCK_BIT];
    assign col_o = rc[BLOCK_BIT-1:0];

endmodule

// File: rtl/dequantizer.sv
// Dequantizer: expands run/value symbols into 64 zigzag-ordered coefficients per
// block, scales each by the loadable quantisation table and presents them on a
// registered valid/ready output.
//
// Handshake rule for every interface: a transfer happens on a rising clock edge
// where valid and ready are both high; a valid output is held stable until it
// is taken.
module dequantizer
    import dequantizer_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [QT_BIT-1:0]    qt_veri_i,
    input  logic                 qt_gecerli_i,
    output logic                 qt_hazir_o,
    input  logic [RUN_BIT-1:0]   ed_run_i,
    input  logic [COEF_BIT-1:0]  ed_veri_i,
    input  logic                 ed_eob_i,
    input  logic                 ed_gecerli_i,
    output logic                 ed_hazir_o,
    output logic [Q_BIT-1:0]     dq_veri_o,
    output logic [BLOCK_BIT-1:0] dq_row_o,
    output logic [BLOCK_BIT-1:0] dq_col_o,
    output logic                 dq_gecerli_o,
    output logic                 dq_blok_son_o,
    input  logic                 dq_hazir_i,
    output logic                 hata_o
);

    dq_state_e                 state_q;
    logic [BLOCK_AREA_BIT-1:0] k_q;          // next zigzag position to emit
    logic [BLOCK_AREA_BIT-1:0] pend_zero_q;  // zeros still owed by the last symbol
    logic                      pend_val_q;   // value still owed after those zeros
    logic [COEF_BIT-1:0]       val_q;
    logic [QT_BIT-1:0]         qt_q [BLOCK_AREA];
    logic [BLOCK_AREA_BIT-1:0] qt_ptr_q;

    logic [Q_BIT-1:0]          dq_veri_q;
    logic [BLOCK_BIT-1:0]      dq_row_q;
    logic [BLOCK_BIT-1:0]      dq_col_q;
    logic                      dq_gecerli_q;
    logic                      dq_blok_son_q;
    logic                      hata_q;

    logic                      stage_free;
    logic                      in_bos;
    logic                      pending;
    logic                      ed_acc;
    logic                      run_ovf;
    logic                      emit;
    logic                      emit_val;
    logic [COEF_BIT-1:0]       emit_coef;
    logic [Q_BIT-1:0]          dq_veri_d;
    logic [BLOCK_BIT-1:0]      lut_row;
    logic [BLOCK_BIT-1:0]      lut_col;

    assign stage_free = !dq_gecerli_q || dq_hazir_i;
    assign in_bos     = (state_q == ST_BOS);
    assign pending    = (pend_zero_q != '0) || pend_val_q;

    // Table loading wins over symbols between blocks; inside a block a new
    // symbol is taken only once the previous one is fully expanded.
    assign qt_hazir_o = in_bos;
    assign ed_hazir_o = in_bos ? (!qt_gecerli_i && stage_free)
                               : ((state_q == ST_BLOK) && !pending && stage_free);
    assign ed_acc     = ed_gecerli_i && ed_hazir_o;

    // A run that would step past k=63 cannot place its value in this block.
    assign run_ovf = (7'({1'b0, k_q}) + 7'(ed_run_i)) > 7'(LAST_K);

    zigzag_lut u_zigzag (
        .k_i   (k_q),
        .row_o (lut_row),
        .col_o (lut_col)
    );

    // Pick what (if anything) goes into the output register this cycle.
    always_comb begin
        emit      = 1'b0;
        emit_val  = 1'b0;
        emit_coef = val_q;
        if (ed_acc) begin
            emit = 1'b1;
            if (!ed_eob_i && !run_ovf && (ed_run_i == '0)) begin
                emit_val  = 1'b1;
                emit_coef = ed_veri_i;
            end
        end else if ((state_q == ST_BLOK) && stage_free && pending) begin
            emit     = 1'b1;
            emit_val = (pend_zero_q == '0);
        end else if ((state_q == ST_DOLDUR) && stage_free) begin
            emit = 1'b1;
        end
    end

    // Scaled coefficient for the position being emitted; zeros stay zero.
    always_comb begin
        dq_veri_d = '0;
        if (emit_val) begin
            dq_veri_d = deq_scale(emit_coef, qt_q[k_q]);
        end
    end

    // Quantisation table: reset to all ones, written sequentially between blocks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BLOCK_AREA; i++) begin
                qt_q[i] <= QT_BIT'(1);
            end
            qt_ptr_q <= '0;
        end else if (in_bos && qt_gecerli_i) begin
            qt_q[qt_ptr_q] <= qt_veri_i;
            qt_ptr_q       <= qt_ptr_q + 1'b1;
        end
    end

    // Block FSM, run expansion bookkeeping and the registered output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_BOS;
            k_q           <= '0;
            pend_zero_q   <= '0;
            pend_val_q    <= 1'b0;
            val_q         <= '0;
            dq_veri_q     <= '0;
            dq_row_q      <= '0;
            dq_col_q      <= '0;
            dq_gecerli_q  <= 1'b0;
            dq_blok_son_q <= 1'b0;
            hata_q        <= 1'b0;
        end else begin
            hata_q <= ed_acc && !ed_eob_i && run_ovf;

            if (ed_acc) begin
                if (ed_eob_i) begin
                    state_q <= ST_DOLDUR;
                end else begin
                    state_q <= ST_BLOK;
                    val_q   <= ed_veri_i;
                    if (run_ovf) begin
                        // zero at k now, remaining zeros through 63, value dropped
                        pend_zero_q <= LAST_K - k_q;
                        pend_val_q  <= 1'b0;
                    end else if (ed_run_i != '0) begin
                        pend_zero_q <= {2'b00, ed_run_i} - 6'd1;
                        pend_val_q  <= 1'b1;
                    end
                end
            end else if ((state_q == ST_BLOK) && stage_free && pending) begin
                if (pend_zero_q != '0) begin
                    pend_zero_q <= pend_zero_q - 6'd1;
                end else begin
                    pend_val_q <= 1'b0;
                end
            end

            if (emit) begin
                k_q           <= k_q + 6'd1;
                dq_gecerli_q  <= 1'b1;
                dq_veri_q     <= dq_veri_d;
                dq_row_q      <= lut_row;
                dq_col_q      <= lut_col;
                dq_blok_son_q <= (k_q == LAST_K);
                if (k_q == LAST_K) begin
                    // last coefficient is in the output register; block is closed
                    state_q     <= ST_BOS;
                    pend_zero_q <= '0;
                    pend_val_q  <= 1'b0;
                end
            end else if (dq_hazir_i) begin
                dq_gecerli_q  <= 1'b0;
                dq_blok_son_q <= 1'b0;
            end
        end
    end

    assign dq_veri_o     = dq_veri_q;
    assign dq_row_o      = dq_row_q;
    assign dq_col_o      = dq_col_q;
    assign dq_gecerli_o  = dq_gecerli_q;
    assign dq_blok_son_o = dq_blok_son_q;
    assign hata_o        = hata_q;

endmodule

// File: tb/tb_dequantizer.sv
// Bench for dequantizer: behavioural block model, per-cycle output compare,
// directed corner blocks and randomized blocks under back-pressure.
module tb_dequantizer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  qt_veri_i;
  logic        qt_gecerli_i;
  logic        qt_hazir_o;
  logic [3:0]  ed_run_i;
  logic [11:0] ed_veri_i;
  logic        ed_eob_i;
  logic        ed_gecerli_i;
  logic        ed_hazir_o;
  logic [31:0] dq_veri_o;
  logic [2:0]  dq_row_o;
  logic [2:0]  dq_col_o;
  logic        dq_gecerli_o;
  logic        dq_blok_son_o;
  logic        dq_hazir_i;
  logic        hata_o;

  dequantizer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .qt_veri_i     (qt_veri_i),
    .qt_gecerli_i  (qt_gecerli_i),
    .qt_hazir_o    (qt_hazir_o),
    .ed_run_i      (ed_run_i),
    .ed_veri_i     (ed_veri_i),
    .ed_eob_i      (ed_eob_i),
    .ed_gecerli_i  (ed_gecerli_i),
    .ed_hazir_o    (ed_hazir_o),
    .dq_veri_o     (dq_veri_o),
    .dq_row_o      (dq_row_o),
    .dq_col_o      (dq_col_o),
    .dq_gecerli_o  (dq_gecerli_o),
    .dq_blok_son_o (dq_blok_son_o),
    .dq_hazir_i    (dq_hazir_i),
    .hata_o        (hata_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Item layout: {data[31:0], row[2:0], col[2:0], last}
  int zr[64];
  int zc[64];
  int m_tbl[64];
  int m_ptr;
  int m_k;
  logic [38:0] exp_q[$];
  logic [38:0] got_q[$];
  bit hata_exp;
  int hata_cnt = 0;
  int cyc = 0;
  int blk_xfers = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit bp_en = 1'b0;

  function automatic logic [31:0] f_deq(input int v, input int q);
    int p;
    p = v * q;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 32'(p * 65536);
  endfunction

  function automatic logic [38:0] f_item(input int k, input logic [31:0] d);
    return {d, 3'(zr[k]), 3'(zc[k]), (k == 63)};
  endfunction

  task automatic m_reset();
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_ptr = 0;
    m_k = 0;
    hata_exp = 1'b0;
  endtask

  // Zigzag order from walking the anti-diagonals, direction alternating.
  task automatic build_zigzag();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zr[k] = r; zc[k] = s - r; k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zr[k] = r; zc[k] = s - r; k++;
        end
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    logic [38:0] x;
    logic [38:0] obs;
    int r;
    int v;
    build_zigzag();
    m_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_i) begin
        if (m_k != 0) chk("qt_hazir_in_block", qt_hazir_o, 0);
        else if (exp_q.size() == 0) chk("qt_hazir_idle", qt_hazir_o, 1);
      end
      if (dq_gecerli_o) begin
        obs = {dq_veri_o, dq_row_o, dq_col_o, dq_blok_son_o};
        if (exp_q.size() == 0) begin
          chk("spurious_valid", dq_gecerli_o, 0);
        end else begin
          chk("dq_out", obs, exp_q[0]);
          if (dq_hazir_i) begin
            got_q.push_back(obs);
            x = exp_q.pop_front();
            if (x[6:1] == 6'd0) begin
              first_cyc = cyc;
              blk_xfers = 1;
            end else begin
              blk_xfers++;
            end
            if (x[0]) last_cyc = cyc;
          end
        end
      end
      chk("hata", hata_o, hata_exp);
      if (hata_o) hata_cnt++;
      hata_exp = 1'b0;
      if (rst_i) begin
        m_reset();
      end else begin
        if (qt_gecerli_i && qt_hazir_o) begin
          if (ed_gecerli_i) chk("ed_hazir_vs_qt", ed_hazir_o, 0);
          m_tbl[m_ptr] = int'(qt_veri_i);
          m_ptr = (m_ptr + 1) % 64;
        end
        if (ed_gecerli_i && ed_hazir_o) begin
          r = int'(ed_run_i);
          v = int'($signed(ed_veri_i));
          if (ed_eob_i) begin
            for (int k = m_k; k < 64; k++) exp_q.push_back(f_item(k, 32'h0));
            m_k = 0;
          end else if (m_k + r > 63) begin
            for (int k = m_k; k < 64; k++) exp_q.push_back(f_item(k, 32'h0));
            m_k = 0;
            hata_exp = 1'b1;
          end else begin
            for (int i = 0; i < r; i++) exp_q.push_back(f_item(m_k + i, 32'h0));
            exp_q.push_back(f_item(m_k + r, f_deq(v, m_tbl[m_k + r])));
            m_k = (m_k + r + 1) % 64;
          end
        end
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      dq_hazir_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int r, input int v, input bit eob);
    int n;
    ed_run_i = 4'(r);
    ed_veri_i = 12'(v);
    ed_eob_i = eob;
    ed_gecerli_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ed_hazir_o && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("ed_timeout", ed_hazir_o, 1);
    @(posedge clk);
    #1;
    ed_gecerli_i = 1'b0;
  endtask

  task automatic load_qt(input int val);
    int n;
    qt_veri_i = 8'(val);
    qt_gecerli_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!qt_hazir_o && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("qt_timeout", qt_hazir_o, 1);
    @(posedge clk);
    #1;
    qt_gecerli_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int h0;
    int cnt;
    int n;
    int guard;
    int r;
    int v;
    bit eob;
    rst_i = 1'b1;
    qt_veri_i = '0;
    qt_gecerli_i = 1'b0;
    ed_run_i = '0;
    ed_veri_i = '0;
    ed_eob_i = 1'b0;
    ed_gecerli_i = 1'b0;
    dq_hazir_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // reset state
    chk("rst_valid", dq_gecerli_o, 0);
    chk("rst_data", dq_veri_o, 0);
    chk("rst_row", dq_row_o, 0);
    chk("rst_col", dq_col_o, 0);
    chk("rst_blok_son", dq_blok_son_o, 0);
    chk("rst_hata", hata_o, 0);
    chk("rst_qt_hazir", qt_hazir_o, 1);

    // pin the model against hand-computed values
    chk("pin_deq_5x2", f_deq(5, 2), 32'h000A0000);
    chk("pin_deq_m3x4", f_deq(-3, 4), 32'hFFF40000);
    chk("pin_sat_pos", f_deq(2047, 255), 32'h7FFF0000);
    chk("pin_sat_neg", f_deq(-2048, 255), 32'h80000000);
    chk("pin_zz2", zr[2] * 8 + zc[2], 8);
    chk("pin_zz35", zr[35] * 8 + zc[35], 56);
    chk("pin_zz63", zr[63] * 8 + zc[63], 63);

    // table all 2, (r0,v5) then EOB at full rate
    for (int i = 0; i < 64; i++) load_qt(2);
    got_q.delete();
    send_sym(0, 5, 1'b0);
    send_sym(0, 0, 1'b1);
    wait_drain();
    chk("b1_count", got_q.size(), 64);
    chk("b1_k0", got_q[0], {32'h000A0000, 3'd0, 3'd0, 1'b0});
    chk("b1_k1", got_q[1], {32'h0, 3'd0, 3'd1, 1'b0});
    chk("b1_k63", got_q[63], {32'h0, 3'd7, 3'd7, 1'b1});
    cnt = 0;
    foreach (got_q[i]) if (got_q[i][0]) cnt++;
    chk("b1_blok_son_count", cnt, 1);
    chk("b1_consecutive", last_cyc - first_cyc, 63);

    // table with 255/4/4/255 at the front, saturation and negative values
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i == 3) load_qt(255);
      else if (i == 1 || i == 2) load_qt(4);
      else load_qt($urandom_range(1, 255));
    end
    got_q.delete();
    send_sym(0, 2047, 1'b0);
    send_sym(1, -3, 1'b0);
    send_sym(0, -2048, 1'b0);
    send_sym(0, 0, 1'b1);
    wait_drain();
    chk("b2_sat_pos", got_q[0], {32'h7FFF0000, 3'd0, 3'd0, 1'b0});
    chk("b2_k1_zero", got_q[1], {32'h0, 3'd0, 3'd1, 1'b0});
    chk("b2_neg", got_q[2], {32'hFFF40000, 3'd1, 3'd0, 1'b0});
    chk("b2_sat_neg", got_q[3], {32'h80000000, 3'd2, 3'd0, 1'b0});

    // run overflow at k=60
    h0 = hata_cnt;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_sym(15, 0, 1'b0);
    send_sym(11, 1, 1'b0);
    send_sym(5, 7, 1'b0);
    wait_drain();
    chk("ovf_hata_pulses", hata_cnt - h0, 1);
    chk("ovf_count", got_q.size(), 64);
    chk("ovf_k63", got_q[63], {32'h0, 3'd7, 3'd7, 1'b1});
    chk("ovf_bos", qt_hazir_o, 1);

    // value landing exactly on k=63 closes the block without EOB
    got_q.delete();
    for (int i = 0; i < 3; i++) send_sym(15, 0, 1'b0);
    send_sym(15, 3, 1'b0);
    wait_drain();
    chk("k63_count", got_q.size(), 64);
    chk("k63_last", got_q[63][0], 1);
    chk("k63_bos", qt_hazir_o, 1);

    // EOB at k=0
    got_q.delete();
    send_sym(0, 0, 1'b1);
    wait_drain();
    chk("eob0_count", got_q.size(), 64);
    cnt = 0;
    foreach (got_q[i]) if (got_q[i][38:7] != 32'h0) cnt++;
    chk("eob0_all_zero", cnt, 0);

    // randomized blocks with back-pressure and partial table loads
    bp_en = 1'b1;
    for (int b = 0; b < 12; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 70);
        for (int i = 0; i < n; i++) load_qt($urandom_range(0, 255));
      end
      got_q.delete();
      guard = 0;
      do begin
        eob = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 4095) - 2048;
        else v = $urandom_range(0, 40) - 20;
        send_sym(r, v, eob);
        guard++;
      end while (m_k != 0 && guard < 100);
      wait_drain();
      chk("rand_block_count", got_q.size(), 64);
    end
    bp_en = 1'b0;
    idle(2);

    // mid-block reset after 20 coefficients
    send_sym(15, 0, 1'b0);
    send_sym(15, 0, 1'b0);
    n = 0;
    while (blk_xfers < 20 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_progress", blk_xfers >= 20, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("mid_rst_valid", dq_gecerli_o, 0);
    chk("mid_rst_blok_son", dq_blok_son_o, 0);
    chk("mid_rst_qt_hazir", qt_hazir_o, 1);
    got_q.delete();
    send_sym(0, 3, 1'b0);
    send_sym(0, 0, 1'b1);
    wait_drain();
    chk("post_rst_k0", got_q[0], {32'h00030000, 3'd0, 3'd0, 1'b0});
    chk("post_rst_count", got_q.size(), 64);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
